// File: rtl/tx_resp_arbiter.sv
// tx_resp_arbiter: round-robin arbiter feeding the write side of the TX async FIFO.
// Three REF_CLK-domain response sources (register read byte, 16-bit ALU result,
// UART error status) are granted one at a time. The granted payload is latched and
// written to the FIFO one byte per cycle, stalling while the FIFO is full.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_valid/rd_data/rd_ready      register read response handshake (1 byte)
//   alu_valid/alu_data/alu_ready   ALU result handshake (2 bytes, low first)
//   err_valid/err_code/err_ready   error status handshake ({parity, framing})
//   fifo_full                FIFO write-side full flag
//   fifo_wdata, fifo_winc    FIFO write data and write strobe
//   busy                     registered, high while a payload is being sent
//   tx_count                 running count of bytes written, wraps silently
module tx_resp_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_valid,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_ready,
    input  logic                    alu_valid,
    input  logic [2*DATA_WIDTH-1:0] alu_data,
    output logic                    alu_ready,
    input  logic                    err_valid,
    input  logic [1:0]              err_code,
    output logic                    err_ready,
    input  logic                    fifo_full,
    output logic [DATA_WIDTH-1:0]   fifo_wdata,
    output logic                    fifo_winc,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    tx_count
);

    localparam int unsigned HOLD_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_ONE = 2'd1,
        SEND_LO  = 2'd2,
        SEND_HI  = 2'd3
    } state_t;

    localparam logic [1:0] SRC_RD  = 2'd0;
    localparam logic [1:0] SRC_ALU = 2'd1;
    localparam logic [1:0] SRC_ERR = 2'd2;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [1:0]          last_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                busy_q;
    logic [2:0]          req;
    logic [2:0]          gnt;

    assign req = {err_valid, alu_valid, rd_valid};

    // Round-robin grant: search starts at the source after the last one granted.
    always_comb begin
        gnt = 3'b000;
        if (state_q == IDLE && !rst) begin
            case (last_q)
                SRC_RD: begin
                    if      (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                SRC_ALU: begin
                    if      (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
                default: begin
                    if      (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    assign rd_ready  = gnt[0];
    assign alu_ready = gnt[1];
    assign err_ready = gnt[2];

    // Write strobe follows the state register, so an async reset kills it at once.
    assign fifo_winc  = (state_q != IDLE) && !fifo_full;
    assign fifo_wdata = (state_q == SEND_HI) ? hold_q[HOLD_W-1:DATA_WIDTH]
                                             : hold_q[DATA_WIDTH-1:0];
    assign busy       = busy_q;
    assign tx_count   = cnt_q;

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt[1])                   state_d = SEND_LO;
                else if (gnt[0] || gnt[2])    state_d = SEND_ONE;
            end
            SEND_ONE: if (!fifo_full) state_d = IDLE;
            SEND_LO:  if (!fifo_full) state_d = SEND_HI;
            SEND_HI:  if (!fifo_full) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, payload hold, round-robin pointer and byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= SRC_ERR;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (fifo_winc) cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (gnt[0]) begin
                hold_q <= HOLD_W'(rd_data);
                last_q <= SRC_RD;
            end else if (gnt[1]) begin
                hold_q <= alu_data;
                last_q <= SRC_ALU;
            end else if (gnt[2]) begin
                hold_q <= HOLD_W'({6'b111000, err_code});
                last_q <= SRC_ERR;
            end
        end
    end

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Bench for tx_resp_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference of the expected byte stream.
module tb_tx_resp_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_valid, alu_valid, err_valid, fifo_full;
    logic [7:0]  rd_data;
    logic [15:0] alu_data;
    logic [1:0]  err_code;
    logic        rd_ready, alu_ready, err_ready, fifo_winc, busy;
    logic [7:0]  fifo_wdata;
    logic [15:0] tx_count;
    logic        d4_rd_ready, d4_alu_ready, d4_err_ready, d4_fifo_winc, d4_busy;
    logic [7:0]  d4_fifo_wdata;
    logic [3:0]  d4_tx_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tx_resp_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .alu_valid(alu_valid), .alu_data(alu_data), .alu_ready(alu_ready),
        .err_valid(err_valid), .err_code(err_code), .err_ready(err_ready),
        .fifo_full(fifo_full), .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc),
        .busy(busy), .tx_count(tx_count)
    );

    // Narrow-counter copy sharing the same stimulus, for the wrap case.
    tx_resp_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(d4_rd_ready),
        .alu_valid(alu_valid), .alu_data(alu_data), .alu_ready(d4_alu_ready),
        .err_valid(err_valid), .err_code(err_code), .err_ready(d4_err_ready),
        .fifo_full(fifo_full), .fifo_wdata(d4_fifo_wdata), .fifo_winc(d4_fifo_winc),
        .busy(d4_busy), .tx_count(d4_tx_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: pending bytes of the granted payload, round-robin pointer, byte count.
    logic [7:0]  exp_q[$];
    int          m_last = 2;
    logic [15:0] m_cnt  = '0;
    logic [7:0]  wlog[$];
    int          glog[$];
    logic [2:0]  acc = '0;
    bit          rand_mode = 1'b0;

    always @(negedge clk) begin
        logic [2:0] rdy, v, eg;
        int         g;
        rdy = {err_ready, alu_ready, rd_ready};
        if (rst) begin
            chk("rst_ready", 32'(rdy), 32'd0);
            chk("rst_winc", 32'(fifo_winc), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_count", 32'(tx_count), 32'd0);
            chk("rst_wdata", 32'(fifo_wdata), 32'd0);
            exp_q.delete();
            m_last = 2;
            m_cnt  = '0;
            acc    = '0;
        end else begin
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("tx_count", 32'(tx_count), 32'(m_cnt));
            chk("tx_count4", 32'(d4_tx_count), 32'(m_cnt[3:0]));
            if (exp_q.size() == 0) begin
                v  = {err_valid, alu_valid, rd_valid};
                eg = '0;
                g  = -1;
                for (int i = 1; i <= 3; i++) begin
                    int idx;
                    idx = (m_last + i) % 3;
                    if (g < 0 && v[idx]) g = idx;
                end
                if (g >= 0) eg[g] = 1'b1;
                chk("grant", 32'(rdy), 32'(eg));
                chk("idle_winc", 32'(fifo_winc), 32'd0);
                if (g == 0) exp_q.push_back(rd_data);
                if (g == 1) begin
                    exp_q.push_back(alu_data[7:0]);
                    exp_q.push_back(alu_data[15:8]);
                end
                if (g == 2) exp_q.push_back({6'b111000, err_code});
                if (g >= 0) begin
                    m_last = g;
                    glog.push_back(g);
                end
            end else begin
                chk("busy_ready", 32'(rdy), 32'd0);
                chk("winc", 32'(fifo_winc), 32'(!fifo_full));
                chk("wdata", 32'(fifo_wdata), 32'(exp_q[0]));
                if (!fifo_full) begin
                    void'(exp_q.pop_front());
                    m_cnt = m_cnt + 16'd1;
                end
            end
            if (fifo_winc) wlog.push_back(fifo_wdata);
            acc = rdy;
        end
    end

    // Random sources: data held while valid is pending, refreshed once accepted.
    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            if (!rd_valid || acc[0]) begin
                rd_valid = ($urandom_range(0, 2) == 0);
                rd_data  = 8'($urandom);
            end
            if (!alu_valid || acc[1]) begin
                alu_valid = ($urandom_range(0, 2) == 0);
                alu_data  = 16'($urandom);
            end
            if (!err_valid || acc[2]) begin
                err_valid = ($urandom_range(0, 3) == 0);
                err_code  = 2'($urandom);
            end
            fifo_full = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd_valid = 1'b0; alu_valid = 1'b0; err_valid = 1'b0; fifo_full = 1'b0;
        rd_data = '0; alu_data = '0; err_code = '0;
        repeat (2) tick();
        rst = 1'b0;

        // Single read response.
        wlog.delete();
        rd_valid = 1'b1; rd_data = 8'hA5;
        @(negedge clk);
        chk("rd_ready_N", 32'(rd_ready), 32'd1);
        tick();
        rd_valid = 1'b0;
        @(negedge clk);
        chk("rd_winc_N1", 32'(fifo_winc), 32'd1);
        chk("rd_wdata_N1", 32'(fifo_wdata), 32'hA5);
        tick();
        @(negedge clk);
        chk("rd_busy_N2", 32'(busy), 32'd0);
        chk("rd_count", 32'(tx_count), 32'd1);
        tick();

        // ALU response: low byte then high byte.
        wlog.delete();
        alu_valid = 1'b1; alu_data = 16'h1234;
        tick();
        alu_valid = 1'b0;
        repeat (3) tick();
        chk("alu_nbytes", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("alu_lo", 32'(wlog[0]), 32'h34);
            chk("alu_hi", 32'(wlog[1]), 32'h12);
        end
        chk("alu_count", 32'(tx_count), 32'd3);

        // FIFO full for three cycles after the low byte.
        wlog.delete();
        alu_valid = 1'b1; alu_data = 16'hBEEF;
        tick();
        alu_valid = 1'b0;
        tick();
        fifo_full = 1'b1;
        repeat (3) tick();
        fifo_full = 1'b0;
        repeat (3) tick();
        chk("stall_nbytes", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("stall_lo", 32'(wlog[0]), 32'hEF);
            chk("stall_hi", 32'(wlog[1]), 32'hBE);
        end
        chk("stall_count", 32'(tx_count), 32'd5);

        // Contention with all sources held valid from reset.
        rst = 1'b1;
        rd_valid = 1'b1; rd_data = 8'hA5;
        alu_valid = 1'b1; alu_data = 16'h1234;
        err_valid = 1'b1; err_code = 2'b01;
        repeat (2) tick();
        rst = 1'b0;
        wlog.delete();
        glog.delete();
        repeat (9) tick();
        rd_valid = 1'b0; alu_valid = 1'b0; err_valid = 1'b0;
        repeat (4) tick();
        chk("rr_ngrants", 32'(glog.size() >= 4), 32'd1);
        chk("rr_nbytes", 32'(wlog.size() >= 4), 32'd1);
        if (glog.size() >= 4 && wlog.size() >= 4) begin
            chk("rr_g0", 32'(glog[0]), 32'd0);
            chk("rr_g1", 32'(glog[1]), 32'd1);
            chk("rr_g2", 32'(glog[2]), 32'd2);
            chk("rr_g3", 32'(glog[3]), 32'd0);
            chk("rr_b0", 32'(wlog[0]), 32'hA5);
            chk("rr_b1", 32'(wlog[1]), 32'h34);
            chk("rr_b2", 32'(wlog[2]), 32'h12);
            chk("rr_b3", 32'(wlog[3]), 32'hE1);
        end

        // Reset while the high byte is being written.
        alu_valid = 1'b1; alu_data = 16'h5678;
        tick();
        alu_valid = 1'b0;
        tick();
        #1;
        chk("hi_winc", 32'(fifo_winc), 32'd1);
        chk("hi_wdata", 32'(fifo_wdata), 32'h56);
        rst = 1'b1;
        #1;
        chk("async_winc", 32'(fifo_winc), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_count", 32'(tx_count), 32'd0);
        tick();
        rst = 1'b0;
        wlog.delete();
        rd_valid = 1'b1; rd_data = 8'h3C;
        tick();
        rd_valid = 1'b0;
        repeat (2) tick();
        chk("post_rst_nbytes", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("post_rst_byte", 32'(wlog[0]), 32'h3C);
        chk("post_rst_count", 32'(tx_count), 32'd1);

        // Counter wrap on the 4-bit copy.
        do_reset();
        for (int n = 0; n < 17; n++) begin
            rd_valid = 1'b1; rd_data = 8'(n);
            tick();
            rd_valid = 1'b0;
            tick();
        end
        tick();
        chk("wrap_count4", 32'(d4_tx_count), 32'd1);
        chk("wrap_count16", 32'(tx_count), 32'd17);

        // Random traffic.
        rand_mode = 1'b1;
        repeat (3000) tick();
        rand_mode = 1'b0;
        rd_valid = 1'b0; alu_valid = 1'b0; err_valid = 1'b0; fifo_full = 1'b0;
        repeat (6) tick();
        chk("drain_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_resp_arbiter.md
# tx_resp_arbiter

Arbitrates the single write port of the TX async FIFO, which crosses from the REF_CLK domain to the UART_CLK domain, among three response sources in the REF_CLK domain:
- register-file read data (one byte),
- ALU results (16 bits, sent as two bytes),
- UART error status (one byte).

It grants requesters round-robin, latches the granted payload and serialises it into FIFO writes while honouring `fifo_full`. It also keeps a running count of bytes written.

## Interface
Parameters:
- `DATA_WIDTH`, 8, FIFO byte width; ALU result width is `2*DATA_WIDTH`.
- `CNT_WIDTH`, 16, width of the written-byte counter.

Ports:
- `clk`  in  1  REF_CLK-domain clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rd_valid`  in  1  register read response pending.
- `rd_data`  in  DATA_WIDTH  read byte; held stable while `rd_valid` is high and `rd_ready` is low.
- `rd_ready`  out  1  one-cycle grant/accept pulse for the read source.
- `alu_valid`  in  1  ALU result pending.
- `alu_data`  in  2*DATA_WIDTH  ALU result; held stable until accepted.
- `alu_ready`  out  1  one-cycle grant/accept pulse for the ALU source.
- `err_valid`  in  1  error status pending.
- `err_code`  in  2  {parity_error, framing_error}.
- `err_ready`  out  1  one-cycle grant/accept pulse for the error source.
- `fifo_full`  in  1  write-side full flag from the async FIFO.
- `fifo_wdata`  out  DATA_WIDTH  byte presented to the FIFO.
- `fifo_winc`  out  1  FIFO write strobe; one byte per asserted cycle.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx_count`  out  CNT_WIDTH  total bytes written; wraps modulo 2^CNT_WIDTH.

## Operation
- States: IDLE, SEND_ONE, SEND_LO, SEND_HI.
- IDLE:
  - If any `*_valid` is high, grant exactly one requester. Assert its `*_ready` combinationally in that same cycle.
  - Capture the payload into the hold register at the clock edge.
  - rd granted: hold = `rd_data`, next state SEND_ONE.
  - err granted: hold = {6'b111000, `err_code`}, next state SEND_ONE.
  - alu granted: hold = `alu_data`, next state SEND_LO.
- Round-robin:
  - A 2-bit `last` register records the most recent grant.
  - Priority order starts at the source after `last`, cycling rd -> alu -> err -> rd.
  - `last` updates only on a grant.
  - The reset value of `last` is err, so after reset the priority is rd > alu > err.
- SEND_ONE:
  - `fifo_wdata` = hold[DATA_WIDTH-1:0].
  - `fifo_winc` = !`fifo_full`.
  - On a write, return to IDLE. Otherwise stay.
- SEND_LO:
  - Write the low byte, then go to SEND_HI.
  - Stall while `fifo_full` is high.
- SEND_HI:
  - Write the high byte, then go to IDLE.
  - Stall while `fifo_full` is high.
- `fifo_winc` is never asserted in IDLE.
- No `*_ready` is asserted outside IDLE.
- `tx_count` increments by 1 on every cycle in which `fifo_winc` = 1.
- Requesters not granted keep `valid` high; no request is dropped.

## Timing
- Reset values:
  - state IDLE, hold 0, `last` = err, `tx_count` 0.
  - `rd_ready`, `alu_ready`, `err_ready`, `fifo_winc` and `busy` are all 0.
  - `fifo_wdata` is 0.
- Reset mid-transfer: the held payload is discarded, `fifo_winc` drops immediately (asynchronously), and the state returns to IDLE. No partial ALU byte pair is resumed.
- Latency: valid seen in IDLE at cycle N -> `*_ready` at cycle N -> first `fifo_winc` at cycle N+1 (FIFO not full).
- Single-byte responses: IDLE is revisited at N+2, giving at most 1 byte per 2 cycles.
- ALU responses: the low byte is written at N+1 and the high byte at N+2 earliest, with IDLE at N+3.
- `fifo_full` is sampled combinationally. Each full cycle delays the pending write by exactly one cycle, with `fifo_wdata` held stable.
- Simultaneous valids: exactly one `*_ready` per IDLE cycle. `*_ready` is one-hot or zero.
- `busy` is registered from state: high from N+1 until the cycle after the last write.
- `tx_count` wraps from 2^CNT_WIDTH-1 to 0 with no flag.

## Test plan
- Single read response after reset:
  - Stimulus: `rd_valid`=1 with `rd_data`=8'hA5, FIFO not full.
  - Required: `rd_ready` at cycle N; `fifo_winc` at N+1 with `fifo_wdata`=8'hA5; `tx_count`=1; `busy` low at N+2.
- ALU response:
  - Stimulus: `alu_data`=16'h1234.
  - Required: writes 8'h34 then 8'h12 on consecutive cycles; `tx_count`=2.
- FIFO full stall:
  - Stimulus: ALU 16'hBEEF with `fifo_full` high for 3 cycles after the low-byte write.
  - Required: 8'hEF written, then 3 idle cycles with `fifo_wdata`=8'hBE held, then 8'hBE written; no extra writes.
- Round-robin under contention:
  - Stimulus: all three valids held high from reset.
  - Required grant order: rd, alu, err, rd; byte stream A5, 34, 12, E1 (`err_code`=2'b01).
- Reset mid-operation:
  - Stimulus: assert `rst` in SEND_HI.
  - Required: `fifo_winc` drops immediately; state IDLE, `tx_count`=0; the next transfer starts cleanly.
- Counter wrap:
  - Stimulus: `CNT_WIDTH`=4 and 17 single-byte writes.
  - Required: `tx_count`=1.
